// File: rtl/dmem_responder.sv
// Data-memory slave for the DAD/DDT/MREQ/WRITE/SIZE/ACKD_n bus: word RAM with byte/half/word lanes.
// Wait states are compiled in with DMEM_WAIT_STATES_EN; without it every access acks in its first cycle.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  output logic        ACKD_n,
  output logic        misalign_err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            lane;
  logic                  stall;
  logic                  ack;
  logic                  illegal;
  logic [31:0]           word;
  logic [31:0]           rdata;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic                  unused_addr_bits;

  assign widx             = DAD[ADDR_WIDTH+1:2];
  assign lane             = DAD[1:0];
  assign unused_addr_bits = ^DAD[31:ADDR_WIDTH+2];

`ifdef DMEM_WAIT_STATES_EN
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (MREQ && WAIT_CYCLES != 0) begin
          stall     = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!MREQ) begin
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          stall   = 1'b1;
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign stall = 1'b0;
`endif

  assign ACKD_n       = stall;
  assign ack          = MREQ & ~stall;
  assign misalign_err = ack & illegal;

  // Read path kept apart from the write path so DDT's tri-state loop stays acyclic.
  always_comb begin
    word    = mem[widx];
    rdata   = '0;
    illegal = 1'b0;
    unique case (SIZE)
      2'b00: rdata = {24'h0, word[{lane, 3'b000} +: 8]};
      2'b01: begin
        illegal = DAD[0];
        rdata   = {16'h0, word[{DAD[1], 4'b0000} +: 16]};
      end
      2'b10: begin
        illegal = |lane;
        rdata   = word;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) rdata = '0;
  end

  always_comb begin
    wdata = DDT;
    be    = '0;
    unique case (SIZE)
      2'b00: begin
        wdata = {4{DDT[7:0]}};
        be    = 4'b0001 << lane;
      end
      2'b01: begin
        wdata = {2{DDT[15:0]}};
        be    = DAD[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   be = '1;
      default: be = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && ack && WRITE && !illegal) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign DDT = (MREQ & ~WRITE & ~stall) ? rdata : 'z;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded random bench for dmem_responder; byte-addressed reference model.
// Adapts its latency expectation to whether DMEM_WAIT_STATES_EN is defined.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int AW = 12;
  localparam int WC = 2;
`ifdef DMEM_WAIT_STATES_EN
  localparam int EXP_WAIT = WC;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct {
    bit        rd;
    bit [31:0] data;
    bit        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] DAD = '0;
  logic        MREQ = 1'b0;
  logic        WRITE = 1'b0;
  logic [1:0]  SIZE = '0;
  logic        drv = 1'b0;
  logic [31:0] wdat = '0;
  wire  [31:0] DDT;
  logic        ACKD_n;
  logic        misalign_err;

  assign DDT = drv ? wdat : 'z;
  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .DAD(DAD), .DDT(DDT), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n), .misalign_err(misalign_err)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit [7:0] mb [int unsigned];

  function automatic bit is_illegal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int unsigned bkey(input logic [31:0] a);
    return a % (32'd1 << (AW + 2));
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] r = '0;
    for (int i = 0; i < (1 << sz); i++) begin
      if (mb.exists(bkey(a + i))) r[8*i +: 8] = mb[bkey(a + i)];
    end
    return r;
  endfunction

  function automatic void m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < (1 << sz); i++) mb[bkey(a + i)] = d[8*i +: 8];
  endfunction

  // Issue one access at posedge+1, wait for its acknowledge, return at the next posedge+1.
  task automatic do_access(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.err  = is_illegal(sz, a);
    e.rd   = !wr;
    e.data = (wr || e.err) ? 32'h0 : m_load(sz, a);
    q.push_back(e);
    if (wr && !e.err) m_store(sz, a, d);
    MREQ = 1'b1; WRITE = wr; SIZE = sz; DAD = a; wdat = d; drv = wr;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (!ACKD_n) break;
      if (n >= 64) begin
        errors++;
        $display("FAIL timeout: no acknowledge for addr %h after %0d cycles, required within %0d", a, n, EXP_WAIT);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    MREQ = 1'b0; drv = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int stalls = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!MREQ) begin
      checks++;
      if (ACKD_n !== 1'b0 || misalign_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_bus: ACKD_n=%b misalign_err=%b, required 0 0", ACKD_n, misalign_err);
      end
      stalls = 0;
    end else if (ACKD_n === 1'b1) begin
      stalls++;
      checks++;
      if (misalign_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_err: misalign_err=%b during stall, required 0", misalign_err);
      end
    end else begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: acknowledge at addr %h with empty scoreboard", DAD);
      end else begin
        e = q.pop_front();
        checks++;
        if (stalls != EXP_WAIT) begin
          errors++;
          $display("FAIL latency: addr %h stalled %0d cycles, required %0d", DAD, stalls, EXP_WAIT);
        end
        checks++;
        if (misalign_err !== e.err) begin
          errors++;
          $display("FAIL misalign: addr %h size %0d err=%b, required %b", DAD, SIZE, misalign_err, e.err);
        end
        if (e.rd) begin
          checks++;
          if (DDT !== e.data) begin
            errors++;
            $display("FAIL read_data: addr %h size %0d got %h, required %h", DAD, SIZE, DDT, e.data);
          end
        end
      end
      stalls = 0;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a;
    logic [1:0]  sz;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known contents for every word the bench will read.
    do_access(1'b1, 2'd2, 32'h200, 32'h0BAD_F00D);
    do_access(1'b1, 2'd2, 32'h300, 32'h3333_CAFE);
    for (int i = 0; i < 16; i++) do_access(1'b1, 2'd2, 32'h400 + 4*i, $urandom);
    idle(2);

    do_access(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF);
    do_access(1'b0, 2'd2, 32'h100, 32'h0);
    idle(1);

    do_access(1'b1, 2'd2, 32'h100, 32'h0000_0000);
    do_access(1'b1, 2'd0, 32'h103, 32'hFFFF_FFA5);
    do_access(1'b0, 2'd2, 32'h100, 32'h0);
    do_access(1'b0, 2'd1, 32'h102, 32'h0);
    idle(1);

    do_access(1'b0, 2'd2, 32'h102, 32'h0);
    do_access(1'b1, 2'd1, 32'h101, 32'h0000_FFFF);
    do_access(1'b0, 2'd2, 32'h100, 32'h0);
    do_access(1'b0, 2'd3, 32'h100, 32'h0);
    idle(1);

`ifdef DMEM_WAIT_STATES_EN
    MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'd2; DAD = 32'h200; wdat = 32'h1234_5678; drv = 1'b1;
    @(posedge clk); #1;
    MREQ = 1'b0; drv = 1'b0;
    @(posedge clk); #1;
    do_access(1'b0, 2'd2, 32'h200, 32'h0);
    do_access(1'b1, 2'd2, 32'h200, 32'h5555_AAAA);
    do_access(1'b0, 2'd2, 32'h200, 32'h0);
    idle(1);

    MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'd2; DAD = 32'h300; wdat = 32'hFFFF_0000; drv = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0; MREQ = 1'b0; drv = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 2'd2, 32'h300, 32'h0);
    idle(1);
`endif

    for (int i = 0; i < 4; i++) begin
      a = 32'h400 + 4 * i;
      do_access(1'b1, 2'd2, a, $urandom);
      do_access(1'b0, 2'd2, a, 32'h0);
    end

    for (int i = 0; i < 300; i++) begin
      a  = 32'h400 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_access(1'($urandom_range(0, 1)), sz, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected responses left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I pipeline's data bus. It is the slave end of the DAD/DDT/MREQ/WRITE/SIZE/ACKD_n protocol and sits outside the core, in the system/testbench top, opposite the MEM stage. It holds a word-organised RAM and serves byte, half and word loads and stores. Optional wait states are signalled through ACKD_n, which exercises the core's interlock path.

## Interface
- ADDR_WIDTH, 12: word-address bits; capacity 2^ADDR_WIDTH words.
- WAIT_CYCLES, 2: stall cycles per access, range 0..15; used only with wait states compiled in.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- DAD  in  32  byte address from the core.
- DDT  inout  32  data bus.
  - Core drives DDT on writes.
  - Responder drives DDT only during a read acknowledge; high-Z otherwise.
- MREQ  in  1  access request; 1 = access.
- WRITE  in  1  1 = store, 0 = load; valid while MREQ=1.
- SIZE  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- ACKD_n  out  1  0 = access completes this cycle, or bus idle; 1 = stall.
- misalign_err  out  1  one-cycle pulse on an acknowledged misaligned or illegal access.

## Operation
- Storage: 2^ADDR_WIDTH x 32-bit array, indexed by DAD[ADDR_WIDTH+1:2].
  - Upper address bits are ignored, so addresses wrap.
  - Contents are not cleared by reset.
- Little-endian; DAD[1:0] selects the byte lane.
- Write data is right-justified on DDT:
  - byte in DDT[7:0], half in DDT[15:0].
  - The responder shifts it into the lane and updates only the enabled bytes.
- Read data is right-justified and zero-extended onto DDT. The core performs sign extension.
- Alignment check, evaluated on the acknowledge cycle:
  - Half with DAD[0]=1, word with DAD[1:0]!=00, or SIZE=11 is illegal.
  - Illegal access: no array write, read returns 32'h0, misalign_err=1 for that cycle.
- FSM states: IDLE, WAIT; 4-bit counter cnt.
  - IDLE, MREQ=0: ACKD_n=0, no action.
  - IDLE, MREQ=1, WAIT_CYCLES=0: acknowledge combinationally (ACKD_n=0); stay IDLE.
  - IDLE, MREQ=1, WAIT_CYCLES>0: ACKD_n=1, cnt<=WAIT_CYCLES-1, go to WAIT.
  - WAIT, MREQ=1, cnt!=0: ACKD_n=1, cnt<=cnt-1.
  - WAIT, MREQ=1, cnt==0: ACKD_n=0 (acknowledge), go to IDLE.
  - WAIT, MREQ=0 (request abandoned, e.g. flush): go to IDLE, no write, ACKD_n=0.
- A write commits at the rising edge that ends its acknowledge cycle.
- The core holds DAD/WRITE/SIZE/DDT stable while ACKD_n=1. Inputs are sampled only on the acknowledge cycle.
- A request seen in IDLE after an acknowledge is always a new access. Back-to-back accesses each incur the full wait.
- Read data is combinational from the array on the acknowledge cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, misalign_err=0, DDT=Z, ACKD_n=0 while MREQ=0.
- Reset asserted mid-access: the access is dropped, no write occurs, and the FSM restarts from IDLE.
- Latency: request first presented in cycle T is acknowledged in cycle T+WAIT_CYCLES.
  - ACKD_n=1 in cycles T..T+WAIT_CYCLES-1.
- Zero-wait: every request completes in its first cycle, including back-to-back loads and stores.
- Store followed by load to the same word: the load in the next access returns the new data. The write is committed before the later acknowledge cycle.
- DDT drive enable = MREQ & ~WRITE & ~ACKD_n. No contention with core writes.

## Configuration
- DMEM_WAIT_STATES_EN defined: FSM, counter and WAIT_CYCLES are active as described.
- DMEM_WAIT_STATES_EN undefined:
  - FSM and counter are removed.
  - ACKD_n is tied to 0.
  - Every access completes in its presentation cycle.
  - WAIT_CYCLES is ignored.

## Test plan
- Store word 32'hDEADBEEF to 0x100, then load word from 0x100, WAIT_CYCLES=2 -> ACKD_n=1,1,0 for each access; load returns 32'hDEADBEEF.
- Store byte 8'hA5 to 0x103 over word 32'h00000000, then load word from 0x100 -> 32'hA5000000; load half from 0x102 -> 32'h0000A500.
- Load word from 0x102 -> misalign_err pulses on the acknowledge cycle, DDT=0; store half to 0x101 -> array unchanged.
- Drop MREQ during WAIT after one stall cycle, then issue a new store to 0x200 -> abandoned access writes nothing; new store takes the full WAIT_CYCLES stall.
- Assert rst_n=0 during WAIT of a store to 0x300 -> ACKD_n=0, state=IDLE; word at 0x300 unchanged.
- Build without DMEM_WAIT_STATES_EN; run four back-to-back store/load pairs -> ACKD_n constantly 0, all reads correct in the same cycle.
